// File: rtl/neokeon_encrypt_core_pkg.sv
// Shared definitions for the iterative Neokeon encryption core:
// FSM encoding, round-constant parameters and 32-bit rotate helpers.
package neokeon_encrypt_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  localparam int          NUM_ROUNDS_DEF = 16;
  localparam logic [7:0]  RC_INIT        = 8'h80;
  localparam logic [7:0]  RC_POLY        = 8'h1B;
  localparam int          CNT_W          = 5;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/neokeon_encrypt_core_round.sv
// Combinational Neokeon round (direct-key, second round constant zero) and the
// fixed rotate-right-by-5 block it uses; theta_o is also the final output transform.
module NeokeonROTR32by5fun (
  input  logic [31:0] din_i,
  output logic [31:0] dout_o
);
  assign dout_o = {din_i[4:0], din_i[31:5]};
endmodule

module neokeon_round_fun
  import neokeon_encrypt_core_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic [7:0]   rc_i,
  output logic [127:0] theta_o,
  output logic [127:0] next_o
);
  logic [31:0] a0, a1, a2, a3, t;
  logic [31:0] g0, g1, g2, g3, sw;
  logic [31:0] g2_r5;

  always_comb begin
    a0 = state_i[127:96] ^ {24'h0, rc_i};
    a1 = state_i[95:64];
    a2 = state_i[63:32];
    a3 = state_i[31:0];
    t  = a0 ^ a2;
    t  = t ^ rotr32(t, 8) ^ rotl32(t, 8);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ key_i[127:96];
    a1 = a1 ^ key_i[95:64];
    a2 = a2 ^ key_i[63:32];
    a3 = a3 ^ key_i[31:0];
    t  = a1 ^ a3;
    t  = t ^ rotr32(t, 8) ^ rotl32(t, 8);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    theta_o = {a0, a1, a2, a3};
    // Pi1 then Gamma; Pi2 is applied on the way out
    g0 = a0;
    g1 = rotl32(a1, 1);
    g2 = rotl32(a2, 5);
    g3 = rotl32(a3, 2);
    g1 = g1 ^ (~g3 & ~g2);
    g0 = g0 ^ (g2 & g1);
    sw = g0;
    g0 = g3;
    g3 = sw;
    g2 = g2 ^ g0 ^ g1 ^ g3;
    g1 = g1 ^ (~g3 & ~g2);
    g0 = g0 ^ (g2 & g1);
  end

  NeokeonROTR32by5fun u_rotr5 (
    .din_i  (g2),
    .dout_o (g2_r5)
  );

  assign next_o = {g0, rotr32(g1, 1), g2_r5, rotr32(g3, 2)};
endmodule

// File: rtl/neokeon_encrypt_core.sv
// Iterative Neokeon encryptor: one round per clock, then a Theta-only final step.
// Inputs are captured at accept; the in-flight block never looks at them again.
module neokeon_encrypt_core
  import neokeon_encrypt_core_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic         inClk,
  input  logic         inRstn,
  input  logic         inStart,
  input  logic [127:0] inKey,
  input  logic [127:0] inDataBlock,
  output logic         outBusy,
  output logic         outValid,
  output logic [127:0] outDataBlock
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS - 1);

  state_e             state_q;
  logic [127:0]       blk_q, key_q, dout_q;
  logic [7:0]         rc_q, rc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, valid_q;
  logic [127:0]       round_next, round_theta;

  neokeon_round_fun u_round (
    .state_i (blk_q),
    .key_i   (key_q),
    .rc_i    (rc_q),
    .theta_o (round_theta),
    .next_o  (round_next)
  );

  // Doubling in GF(2^8) modulo x^8+x^4+x^3+x+1
  assign rc_d = rc_q[7] ? ({rc_q[6:0], 1'b0} ^ RC_POLY) : {rc_q[6:0], 1'b0};

  always_ff @(posedge inClk) begin
    if (!inRstn) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      dout_q  <= '0;
      rc_q    <= RC_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (inStart) begin
            blk_q   <= inDataBlock;
            key_q   <= inKey;
            rc_q    <= RC_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          blk_q <= round_next;
          rc_q  <= rc_d;
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_FINAL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FINAL: begin
          dout_q  <= round_theta;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign outBusy      = busy_q;
  assign outValid     = valid_q;
  assign outDataBlock = dout_q;
endmodule

// File: tb/tb_neokeon_encrypt_core.sv
// Self-checking bench for neokeon_encrypt_core: known vectors, random blocks
// against a word-level reference model, input isolation, back-to-back and reset.
module tb_neokeon_encrypt_core;
  logic         inClk;
  logic         inRstn;
  logic         inStart;
  logic [127:0] inKey;
  logic [127:0] inDataBlock;
  logic         outBusy;
  logic         outValid;
  logic [127:0] outDataBlock;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] VEC0 = 128'hb1656851_699e29fa_24b70148_503d2dfc;
  localparam logic [127:0] VEC1 = 128'h2a78421b_87c7d092_4f26113f_1d1349b2;

  neokeon_encrypt_core #(.NUM_ROUNDS(16)) dut (
    .inClk        (inClk),
    .inRstn       (inRstn),
    .inStart      (inStart),
    .inKey        (inKey),
    .inDataBlock  (inDataBlock),
    .outBusy      (outBusy),
    .outValid     (outValid),
    .outDataBlock (outDataBlock)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  function automatic logic [127:0] ref_theta(input logic [127:0] s, input logic [127:0] k);
    logic [31:0] a [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) a[i] = s[127 - 32*i -: 32];
    t = a[0] ^ a[2];
    t = t ^ rl(t, 24) ^ rl(t, 8);
    a[1] ^= t;
    a[3] ^= t;
    for (int i = 0; i < 4; i++) a[i] ^= k[127 - 32*i -: 32];
    t = a[1] ^ a[3];
    t = t ^ rl(t, 24) ^ rl(t, 8);
    a[0] ^= t;
    a[2] ^= t;
    return {a[0], a[1], a[2], a[3]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s;
    logic [31:0] a [4];
    logic [31:0] tmp;
    int rc;
    s  = p;
    rc = 'h80;
    for (int r = 0; r < 16; r++) begin
      s[103:96] ^= rc[7:0];
      s = ref_theta(s, k);
      for (int i = 0; i < 4; i++) a[i] = s[127 - 32*i -: 32];
      a[1] = rl(a[1], 1);  a[2] = rl(a[2], 5);  a[3] = rl(a[3], 2);
      a[1] ^= ~a[3] & ~a[2];
      a[0] ^= a[2] & a[1];
      tmp = a[0]; a[0] = a[3]; a[3] = tmp;
      a[2] ^= a[0] ^ a[1] ^ a[3];
      a[1] ^= ~a[3] & ~a[2];
      a[0] ^= a[2] & a[1];
      a[1] = rl(a[1], 31); a[2] = rl(a[2], 27); a[3] = rl(a[3], 30);
      s = {a[0], a[1], a[2], a[3]};
      rc = rc * 2;
      if (rc >= 'h100) rc = rc ^ 'h11B;
    end
    s[103:96] ^= rc[7:0];
    return ref_theta(s, k);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic wait_valid(output int lat, output int busy_low);
    lat = 0;
    busy_low = 0;
    do begin
      tick();
      lat++;
      if (!outValid && !outBusy) busy_low++;
    end while (!outValid && lat < 40);
  endtask

  task automatic start_op(input logic [127:0] k, input logic [127:0] p);
    inStart = 1'b1;
    inKey = k;
    inDataBlock = p;
    tick();
    inStart = 1'b0;
    inKey = rand128();
    inDataBlock = rand128();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    inRstn = 1'b0;
    inStart = 1'b1;
    inKey = '1;
    inDataBlock = '1;
    tick();
    tick();
    total++; if (outBusy !== 1'b0) $display("FAIL reset_busy got %b want 0", outBusy); else passed++;
    total++; if (outValid !== 1'b0) $display("FAIL reset_valid got %b want 0", outValid); else passed++;
    total++; if (outDataBlock !== 128'h0) $display("FAIL reset_data got %h want 0", outDataBlock); else passed++;
    inStart = 1'b0;
    inRstn = 1'b1;
    tick();
  endtask

  task automatic test_known(input logic [127:0] k, input logic [127:0] p, input logic [127:0] exp);
    int lat, bl;
    start_op(k, p);
    wait_valid(lat, bl);
    total++; if (lat !== 17) $display("FAIL known_latency got %0d want 17", lat); else passed++;
    total++; if (outDataBlock !== exp) $display("FAIL known_vector got %h want %h", outDataBlock, exp); else passed++;
    total++; if (outDataBlock !== ref_encrypt(k, p)) $display("FAIL known_model got %h want %h", outDataBlock, ref_encrypt(k, p)); else passed++;
    total++; if (bl !== 0) $display("FAIL known_busy_gap got %0d want 0", bl); else passed++;
    total++; if (outBusy !== 1'b0) $display("FAIL known_busy_at_valid got %b want 0", outBusy); else passed++;
    tick();
    total++; if (outValid !== 1'b0) $display("FAIL known_valid_pulse got %b want 0", outValid); else passed++;
    tick();
    total++; if (outDataBlock !== exp) $display("FAIL known_hold got %h want %h", outDataBlock, exp); else passed++;
  endtask

  task automatic test_random();
    logic [127:0] k, p;
    int lat, bl;
    for (int n = 0; n < 4; n++) begin
      k = rand128();
      p = rand128();
      start_op(k, p);
      wait_valid(lat, bl);
      total++; if (lat !== 17) $display("FAIL rand_latency[%0d] got %0d want 17", n, lat); else passed++;
      total++; if (outDataBlock !== ref_encrypt(k, p)) $display("FAIL rand_data[%0d] got %h want %h", n, outDataBlock, ref_encrypt(k, p)); else passed++;
      tick();
    end
  endtask

  task automatic test_ignore_inputs();
    logic [127:0] k0, p0;
    int lat, bl;
    k0 = rand128();
    p0 = rand128();
    inStart = 1'b1;
    inKey = k0;
    inDataBlock = p0;
    tick();
    lat = 0;
    bl = 0;
    do begin
      inKey = rand128();
      inDataBlock = rand128();
      tick();
      lat++;
      if (!outValid && !outBusy) bl++;
    end while (!outValid && lat < 40);
    total++; if (lat !== 17) $display("FAIL ignore_latency got %0d want 17", lat); else passed++;
    total++; if (outDataBlock !== ref_encrypt(k0, p0)) $display("FAIL ignore_data got %h want %h", outDataBlock, ref_encrypt(k0, p0)); else passed++;
    total++; if (bl !== 0) $display("FAIL ignore_busy_gap got %0d want 0", bl); else passed++;
    k0 = inKey;
    p0 = inDataBlock;
    tick();
    inStart = 1'b0;
    inKey = rand128();
    inDataBlock = rand128();
    total++; if (outBusy !== 1'b1) $display("FAIL ignore_second_accept got %b want 1", outBusy); else passed++;
    wait_valid(lat, bl);
    total++; if (lat !== 17) $display("FAIL ignore_second_latency got %0d want 17", lat); else passed++;
    total++; if (outDataBlock !== ref_encrypt(k0, p0)) $display("FAIL ignore_second_data got %h want %h", outDataBlock, ref_encrypt(k0, p0)); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, pa, kb, pb;
    int lat, bl;
    ka = rand128(); pa = rand128();
    kb = rand128(); pb = rand128();
    start_op(ka, pa);
    wait_valid(lat, bl);
    total++; if (outDataBlock !== ref_encrypt(ka, pa)) $display("FAIL b2b_first got %h want %h", outDataBlock, ref_encrypt(ka, pa)); else passed++;
    start_op(kb, pb);
    wait_valid(lat, bl);
    total++; if (lat + 1 !== 18) $display("FAIL b2b_spacing got %0d want 18", lat + 1); else passed++;
    total++; if (bl !== 0) $display("FAIL b2b_busy_gap got %0d want 0", bl); else passed++;
    total++; if (outDataBlock !== ref_encrypt(kb, pb)) $display("FAIL b2b_second got %h want %h", outDataBlock, ref_encrypt(kb, pb)); else passed++;
    tick();
  endtask

  task automatic test_reset_abort();
    int lat, bl, vcnt;
    start_op('0, '0);
    for (int i = 0; i < 7; i++) tick();
    inRstn = 1'b0;
    inStart = 1'b1;
    tick();
    total++; if (outBusy !== 1'b0) $display("FAIL abort_busy got %b want 0", outBusy); else passed++;
    total++; if (outValid !== 1'b0) $display("FAIL abort_valid got %b want 0", outValid); else passed++;
    total++; if (outDataBlock !== 128'h0) $display("FAIL abort_data got %h want 0", outDataBlock); else passed++;
    inStart = 1'b0;
    tick();
    inRstn = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (outValid || outBusy) vcnt++;
    end
    total++; if (vcnt !== 0) $display("FAIL abort_idle_activity got %0d want 0", vcnt); else passed++;
    start_op('0, '0);
    wait_valid(lat, bl);
    total++; if (lat !== 17) $display("FAIL abort_rerun_latency got %0d want 17", lat); else passed++;
    total++; if (outDataBlock !== VEC0) $display("FAIL abort_rerun_data got %h want %h", outDataBlock, VEC0); else passed++;
    tick();
  endtask

  initial begin
    inRstn = 1'b0;
    inStart = 1'b0;
    inKey = '0;
    inDataBlock = '0;
    test_reset();
    test_known('0, '0, VEC0);
    test_known('1, '1, VEC1);
    test_random();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/neokeon_encrypt_core.md
NEOKEON_ENCRYPT_CORE -- requirements
Module: neokeon_encrypt_core

Interface
REQ-001 Parameter NUM_ROUNDS, default 16, number of full Neokeon rounds before the final output transform.
REQ-002 inClk  input  1  system clock; all state updates on the rising edge.
REQ-003 inRstn  input  1  synchronous, active-low reset, sampled on the rising edge of inClk.
REQ-004 inStart  input  1  start request; sampled only in IDLE.
REQ-005 inKey  input  128  working key (direct-key mode); word k0 = bits [127:96].
REQ-006 inDataBlock  input  128  plaintext block; word a0 = bits [127:96], a3 = bits [31:0].
REQ-007 outBusy  output  1  high while an encryption is in progress.
REQ-008 outValid  output  1  one-cycle pulse marking outDataBlock as a new ciphertext.
REQ-009 outDataBlock  output  128  ciphertext; same word order as inDataBlock.

Function
REQ-010 The FSM SHALL have states IDLE, ROUND and FINAL.
REQ-011 In IDLE with inStart=1 at an edge: register inDataBlock into the state register, register inKey into the key register, set RC=8'h80, round counter=0, go to ROUND.
REQ-012 In IDLE with inStart=0: hold all registers; outDataBlock keeps its last value.
REQ-013 Each ROUND edge SHALL apply one round: a0^=RC; Theta(K); Pi1; Gamma; Pi2. The second round constant is 0.
REQ-014 Theta: t=a0^a2; t^=ROTR8(t)^ROTL8(t); a1^=t; a3^=t; ai^=ki for all i; t=a1^a3; t^=ROTR8(t)^ROTL8(t); a0^=t; a2^=t.
REQ-015 Pi1: a1=ROTL1(a1), a2=ROTL5(a2), a3=ROTL2(a3). Pi2: a1=ROTR1(a1), a2=ROTR5(a2), a3=ROTR2(a3).
REQ-016 Gamma: a1^=~a3&~a2; a0^=a2&a1; swap a0 and a3; a2^=a0^a1^a3; a1^=~a3&~a2; a0^=a2&a1.
REQ-017 RC update per round: RC=(RC[7] ? {RC[6:0],1'b0}^8'h1B : {RC[6:0],1'b0}), 8-bit, no carry-out.
REQ-018 After the round with counter=NUM_ROUNDS-1, go to FINAL; otherwise increment the counter and stay in ROUND.
REQ-019 The FINAL edge SHALL apply a0^=RC (8'hD4 for NUM_ROUNDS=16) then Theta(K), load outDataBlock, pulse outValid, and return to IDLE.
REQ-020 Latency: outValid SHALL be high during exactly the cycle following edge N+1, where edge 0 accepts inStart (17 cycles for the default).
REQ-021 outBusy SHALL be high from the cycle after the accept edge until and including the FINAL edge; it is low in the outValid cycle.
REQ-022 inStart, inKey and inDataBlock changes while busy SHALL be ignored. The in-flight operation uses only the values registered at accept.
REQ-023 inStart high in the outValid cycle SHALL be accepted, which allows back-to-back operations with one idle cycle.
REQ-024 All rotations SHALL be 32-bit circular. XOR of RC SHALL affect a0[7:0] only.

Reset
REQ-025 When inRstn=0 at an edge: FSM=IDLE, outBusy=0, outValid=0, outDataBlock=0, state/key registers=0, RC=8'h80, counter=0.
REQ-026 Reset mid-operation SHALL abort without an outValid pulse. The first start after reset SHALL behave as from power-up.
REQ-027 Reset SHALL take priority over inStart on the same edge.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, NUM_ROUNDS default, RC_INIT=8'h80, RC_POLY=8'h1B and the round-counter width.
REQ-029 The combinational round SHALL be one sub-module, neokeon_round_fun (inputs state, key, RC; output next state).
REQ-030 The ROTR5 in Pi2 SHALL reuse the existing NeokeonROTR32by5fun block.
REQ-031 The FINAL transform SHALL reuse the Theta logic of neokeon_round_fun, not a duplicate copy.

Verification
REQ-032 Key=0, block=0, start -> outValid after 17 cycles, outDataBlock=128'hb1656851_699e29fa_24b70148_503d2dfc.
REQ-033 Key=all-ones, block=all-ones -> outDataBlock=128'h2a78421b_87c7d092_4f26113f_1d1349b2.
REQ-034 inStart held high and inDataBlock changed every cycle during an operation -> result equals the first block's ciphertext; the second start is accepted only at the outValid cycle.
REQ-035 Drive inRstn=0 at round 7, then start with key=0, block=0 -> no outValid from the aborted run; the new run gives the REQ-032 vector; all outputs are 0 during reset.
REQ-036 Probe RC per round -> 80,1B,36,6C,D8,AB,4D,9A,2F,5E,BC,63,C6,97,35,6A, then D4 in FINAL.
REQ-037 Two back-to-back starts -> two outValid pulses 18 cycles apart, each with the correct ciphertext; outBusy is low only in the outValid cycles.
